// File: rtl/memunit_pkg.sv
// Shared definitions for the write-back data-memory unit: FSM state
// encoding, load/store size encodings (funct3) and address-field widths.
package memunit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of a line address: byte address minus byte-lane and word-offset bits.
  function automatic int line_addr_width(int addr_w, int block_size);
    return addr_w - 2 - block_size;
  endfunction

  // Width of the tag: line address minus the set-index bits.
  function automatic int tag_width(int addr_w, int sets_log2, int block_size);
    return addr_w - 2 - block_size - sets_log2;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper for the memory unit: merges store data into a 32-bit
// word by size and byte lane, and extracts/extends load data from a word.
// Purely combinational; the cache uses it for both first-time hits and the
// replayed access after a refill.
module mem_lane_align
  import memunit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the stored word.
  always_comb begin
    sel_byte = word[8*byte_off +: 8];
    sel_half = byte_off[1] ? word[31:16] : word[15:0];
  end

  // Store merge: only the lanes covered by the access size change.
  always_comb begin
    merged = word;
    case (funct3)
      F3_B, F3_BU: merged[8*byte_off +: 8] = wdata[7:0];
      F3_H, F3_HU: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      default:     merged = wdata;
    endcase
  end

  // Load extend: signed sizes replicate the top bit, unsigned sizes pad zeros.
  always_comb begin
    loaded = word;
    case (funct3)
      F3_B:    loaded = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    loaded = {{16{sel_half[15]}}, sel_half};
      F3_BU:   loaded = {24'd0, sel_byte};
      F3_HU:   loaded = {16'd0, sel_half};
      F3_W:    loaded = word;
      default: loaded = word;
    endcase
  end

endmodule

// File: rtl/writeback_memoryunit.sv
// MEM-stage data cache: N-set, 1- or 2-way, write-back/write-allocate with
// dirty bits and per-set LRU. Misses freeze the pipeline via stall while a
// small FSM (IDLE -> [WRITEBACK] -> REFILL -> IDLE) exchanges whole lines
// with a variable-latency backing memory. After the refill the access
// replays in IDLE as an ordinary hit.
//
// Backing-memory handshake: mem_req/mem_we/mem_address/mem_wdata are held
// stable from the first request cycle until the cycle in which mem_ready is
// high; that cycle completes the request. mem_ready is ignored in IDLE.
//
// Optional feature macro: MEMUNIT_STATS_EN adds hit_count/miss_count.
// state_dbg exposes the FSM state for observation.
module writeback_memoryunit
  import memunit_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SETS_LOG2     = 3,
  parameter int BLOCK_SIZE    = 3,
  parameter int WAYS          = 2
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [ADDRESS_WIDTH-1:0]                            address,
  input  logic [DATA_WIDTH-1:0]                               write_data,
  input  logic [2:0]                                          DATAMEMControl,
  input  logic                                                write_enable,
  input  logic                                                read_enable,
  output logic [DATA_WIDTH-1:0]                               read_data,
  output logic                                                stall,
  output logic                                                mem_req,
  output logic                                                mem_we,
  output logic [line_addr_width(ADDRESS_WIDTH, BLOCK_SIZE)-1:0] mem_address,
  output logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0]                 mem_wdata,
  input  logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0]                 mem_rdata,
  input  logic                                                mem_ready,
  output logic [1:0]                                          state_dbg
`ifdef MEMUNIT_STATS_EN
  ,
  output logic [31:0]                                         hit_count,
  output logic [31:0]                                         miss_count
`endif
);

  localparam int TAG_W  = tag_width(ADDRESS_WIDTH, SETS_LOG2, BLOCK_SIZE);
  localparam int LINE_W = DATA_WIDTH << BLOCK_SIZE;
  localparam int SETS   = 1 << SETS_LOG2;

  // Cache storage
  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] line_q  [WAYS][SETS];
  logic [SETS-1:0]   lru_q;

  state_t state_q, state_d;
  logic   victim_q;
  logic   victim_sel;

  // Address fields
  logic [BLOCK_SIZE-1:0] off;
  logic [SETS_LOG2-1:0]  idx;
  logic [TAG_W-1:0]      req_tag;

  assign off     = address[BLOCK_SIZE+1:2];
  assign idx     = address[BLOCK_SIZE+2 +: SETS_LOG2];
  assign req_tag = address[ADDRESS_WIDTH-1 -: TAG_W];

  logic                  access;
  logic                  hit;
  logic                  hit_way;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [DATA_WIDTH-1:0] store_word;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  idle_hit;
  logic                  refill_done;
  logic                  stall_raw;

  assign access      = read_enable | write_enable;
  assign idle_hit    = (state_q == IDLE) && access && hit;
  assign refill_done = (state_q == REFILL) && mem_ready;

  // Tag lookup across the ways of the indexed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
  end

  assign hit_word = line_q[hit_way][idx][int'(off)*DATA_WIDTH +: DATA_WIDTH];

  // Victim choice: an invalid way first, otherwise the LRU way.
  generate
    if (WAYS == 1) begin : g_direct
      assign victim_sel = 1'b0;
    end else begin : g_assoc
      always_comb begin
        victim_sel = lru_q[idx];
        if (!valid_q[0][idx])      victim_sel = 1'b0;
        else if (!valid_q[1][idx]) victim_sel = 1'b1;
      end
    end
  endgenerate

  mem_lane_align u_lane (
    .word     (hit_word),
    .wdata    (write_data),
    .funct3   (DATAMEMControl),
    .byte_off (address[1:0]),
    .merged   (store_word),
    .loaded   (load_word)
  );

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !hit) begin
          stall_raw = 1'b1;
          if (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) state_d = WRITEBACK;
          else                                                       state_d = REFILL;
        end
      end
      WRITEBACK: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        if (mem_ready) state_d = REFILL;
      end
      REFILL: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall       = stall_raw & ~rst;
  assign read_data   = (rst || !hit) ? '0 : load_word;
  assign mem_address = (state_q == WRITEBACK) ? {tag_q[victim_q][idx], idx} : {req_tag, idx};
  assign mem_wdata   = line_q[victim_q][idx];
  assign state_dbg   = state_q;

  // FSM state and the victim way latched when a miss is detected.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && access && !hit) victim_q <= victim_sel;
    end
  end

  // Line metadata: valid/dirty/LRU, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      if (idle_hit) begin
        lru_q[idx] <= ~hit_way;
        if (write_enable) dirty_q[hit_way][idx] <= 1'b1;
      end
      if (refill_done) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  // Line data and tags: store merges on hits, whole-line install on refill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (idle_hit && write_enable)
        line_q[hit_way][idx][int'(off)*DATA_WIDTH +: DATA_WIDTH] <= store_word;
      if (refill_done) begin
        line_q[victim_q][idx] <= mem_rdata;
        tag_q[victim_q][idx]  <= req_tag;
      end
    end
  end

`ifdef MEMUNIT_STATS_EN
  logic replay_q;

  // Access statistics; the replayed hit after a refill is not counted again.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay_q   <= 1'b0;
    end else begin
      replay_q <= refill_done;
      if ((state_q == IDLE) && access && !replay_q) begin
        if (hit) hit_count  <= hit_count + 32'd1;
        else     miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_memoryunit.sv
// Bench for writeback_memoryunit: directed scenarios plus a randomized run,
// checked against an architectural memory image and a per-set
// most/least-recently-used tag model. Latencies of the backing memory are
// randomized per request.
module tb_writeback_memoryunit;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [2:0]    DATAMEMControl;
  logic          write_enable;
  logic          read_enable;
  logic [31:0]   read_data;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [26:0]   mem_address;
  logic [255:0]  mem_wdata;
  logic [255:0]  mem_rdata;
  logic          mem_ready;
  logic [1:0]    state_dbg;
`ifdef MEMUNIT_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  writeback_memoryunit dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .write_data     (write_data),
    .DATAMEMControl (DATAMEMControl),
    .write_enable   (write_enable),
    .read_enable    (read_enable),
    .read_data      (read_data),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .state_dbg      (state_dbg)
`ifdef MEMUNIT_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [31:0] bk   [int];   // backing memory, by word address
  logic [31:0] arch [int];   // architectural memory image, by word address
  bit          dirty_m [int];// dirty resident lines, by line address
  int          mru [8];      // most recently used tag per set, -1 empty
  int          lru [8];      // least recently used tag per set, -1 empty
  int          model_hits;
  int          model_misses;
  int          last_stall;
  int          last_nph;

  function automatic logic [31:0] seed_word(int wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bk_word(int wa);
    if (bk.exists(wa)) return bk[wa];
    return seed_word(wa);
  endfunction

  function automatic logic [31:0] arch_word(int wa);
    if (arch.exists(wa)) return arch[wa];
    return bk_word(wa);
  endfunction

  function automatic logic [255:0] line_words(int la, bit use_arch);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = use_arch ? arch_word(la*8 + i) : bk_word(la*8 + i);
    return l;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f, logic [31:0] w, logic [1:0] b);
    logic [31:0] bv;
    logic [31:0] hv;
    bv = (w >> (int'(b) * 8)) & 32'hFF;
    hv = b[1] ? (w >> 16) : (w & 32'hFFFF);
    case (f)
      3'b000:  return (bv ^ 32'h80) - 32'h80;
      3'b001:  return (hv ^ 32'h8000) - 32'h8000;
      3'b100:  return bv;
      3'b101:  return hv;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_store(logic [2:0] f, logic [31:0] old, logic [31:0] wd, logic [1:0] b);
    logic [31:0] mask;
    int          sh;
    case (f)
      3'b000, 3'b100: begin sh = int'(b) * 8;    mask = 32'hFF << sh;   end
      3'b001, 3'b101: begin sh = b[1] ? 16 : 0;  mask = 32'hFFFF << sh; end
      default:        begin sh = 0;              mask = 32'hFFFF_FFFF;  end
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic model_reset();
    arch.delete();
    dirty_m.delete();
    for (int s = 0; s < 8; s++) begin
      mru[s] = -1;
      lru[s] = -1;
    end
    model_hits   = 0;
    model_misses = 0;
  endtask

  // Driver tasks (entered and left at a falling edge)
  task automatic do_reset();
    rst          = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    mem_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_access(input bit we, input bit re, input logic [2:0] f,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd);
    int           la, set, tag, wa, victim_la, cyc, stall_cnt, lat_sum, remain, nph, exp_nph;
    bit           hit, full, wb_exp, done, active, unstable;
    logic [255:0] exp_wb_line;
    logic [31:0]  exp_rd;
    logic         ph_we   [4];
    logic [26:0]  ph_addr [4];
    logic [255:0] ph_data [4];

    la        = int'(addr >> 5);
    set       = la % 8;
    tag       = la / 8;
    wa        = int'(addr >> 2);
    hit       = (mru[set] == tag) || (lru[set] == tag);
    full      = (lru[set] != -1);
    victim_la = lru[set] * 8 + set;
    wb_exp    = !hit && full && dirty_m.exists(victim_la);
    exp_wb_line = line_words(victim_la, 1'b1);
    exp_rd    = exp_load(f, arch_word(wa), addr[1:0]);
    exp_nph   = hit ? 0 : (wb_exp ? 2 : 1);

    address        = addr;
    write_data     = wd;
    DATAMEMControl = f;
    write_enable   = we;
    read_enable    = re;

    stall_cnt = 0; lat_sum = 0; nph = 0; cyc = 0; remain = 0;
    done = 1'b0; active = 1'b0; unstable = 1'b0; rd = '0;
    while (!done && cyc < 100) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        rd   = read_data;
      end else begin
        stall_cnt++;
        if (mem_req) begin
          if (!active) begin
            active  = 1'b1;
            remain  = $urandom_range(1, 4);
            lat_sum += remain;
            if (nph < 4) begin
              ph_we[nph]   = mem_we;
              ph_addr[nph] = mem_address;
              ph_data[nph] = mem_wdata;
            end
            nph++;
            mem_rdata = line_words(int'(mem_address), 1'b0);
          end else if (nph <= 4) begin
            if (mem_we !== ph_we[nph-1] || mem_address !== ph_addr[nph-1] ||
                (mem_we && mem_wdata !== ph_data[nph-1]))
              unstable = 1'b1;
          end
          remain--;
          if (remain == 0) begin
            mem_ready = 1'b1;
            active    = 1'b0;
            if (mem_we)
              for (int i = 0; i < 8; i++) bk[int'(mem_address)*8 + i] = mem_wdata[i*32 +: 32];
          end
        end
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        cyc++;
      end
    end
    if (done) begin
      @(posedge clk);
      @(negedge clk);
    end
    write_enable = 1'b0;
    read_enable  = 1'b0;

    // Scoreboard checks for this access
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL timeout addr=%h stall still high after %0d cycles", addr, cyc);
    end
    tests++;
    if (stall_cnt != (hit ? 0 : 1 + lat_sum)) begin
      fails++;
      $display("FAIL stall_cycles addr=%h got=%0d exp=%0d", addr, stall_cnt, hit ? 0 : 1 + lat_sum);
    end
    tests++;
    if (nph != exp_nph) begin
      fails++;
      $display("FAIL mem_requests addr=%h got=%0d exp=%0d", addr, nph, exp_nph);
    end
    if (nph == exp_nph && exp_nph > 0) begin
      if (wb_exp) begin
        tests++;
        if (ph_we[0] !== 1'b1 || ph_addr[0] !== 27'(victim_la) || ph_data[0] !== exp_wb_line) begin
          fails++;
          $display("FAIL writeback we=%b addr=%h exp_addr=%h data=%h exp_data=%h",
                   ph_we[0], ph_addr[0], 27'(victim_la), ph_data[0], exp_wb_line);
        end
      end
      tests++;
      if (ph_we[nph-1] !== 1'b0 || ph_addr[nph-1] !== 27'(la)) begin
        fails++;
        $display("FAIL refill we=%b addr=%h exp_addr=%h", ph_we[nph-1], ph_addr[nph-1], 27'(la));
      end
      tests++;
      if (unstable) begin
        fails++;
        $display("FAIL request_hold addr=%h got=changed exp=stable", addr);
      end
    end
    if (re && !we) begin
      tests++;
      if (rd !== exp_rd) begin
        fails++;
        $display("FAIL load_data addr=%h f=%0d got=%h exp=%h", addr, f, rd, exp_rd);
      end
    end
    last_stall = stall_cnt;
    last_nph   = nph;

    // Model update
    if (hit) begin
      model_hits++;
      if (mru[set] != tag) begin
        lru[set] = mru[set];
        mru[set] = tag;
      end
    end else begin
      model_misses++;
      if (full) dirty_m.delete(victim_la);
      if (mru[set] != -1) lru[set] = mru[set];
      mru[set] = tag;
    end
    if (we) begin
      arch[wa]    = exp_store(f, arch_word(wa), wd, addr[1:0]);
      dirty_m[la] = 1'b1;
    end
  endtask

  // Tests
  task automatic test_reset();
    rst            = 1'b1;
    mem_ready      = 1'b0;
    mem_rdata      = '0;
    write_enable   = 1'b0;
    read_enable    = 1'b1;
    address        = 32'h100;
    write_data     = '0;
    DATAMEMControl = 3'b010;
    repeat (2) begin
      @(negedge clk);
      #1;
      tests++;
      if (stall !== 1'b0 || read_data !== 32'h0) begin
        fails++;
        $display("FAIL reset_outputs stall=%b read_data=%h exp=0/0", stall, read_data);
      end
    end
    @(negedge clk);
    rst         = 1'b0;
    read_enable = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL after_reset stall=%b mem_req=%b mem_we=%b state=%0d exp=0/0/0/0",
               stall, mem_req, mem_we, state_dbg);
    end
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_lanes();
    logic [31:0] rd;
    do_reset();
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, rd);
    do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'hDEAD_BEEF, rd);
    tests++;
    if (last_stall != 0 || last_nph != 0) begin
      fails++;
      $display("FAIL store_hit_stall got=%0d/%0d exp=0/0", last_stall, last_nph);
    end
    do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, rd);
    tests++;
    if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_after_sw got=%h exp=deadbeef", rd); end
    do_access(1'b1, 1'b0, 3'b000, 32'h105, 32'h80, rd);
    do_access(1'b0, 1'b1, 3'b000, 32'h105, 32'h0, rd);
    tests++;
    if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb got=%h exp=ffffff80", rd); end
    do_access(1'b0, 1'b1, 3'b100, 32'h105, 32'h0, rd);
    tests++;
    if (rd !== 32'h0000_0080) begin fails++; $display("FAIL lbu got=%h exp=00000080", rd); end
    do_access(1'b0, 1'b1, 3'b001, 32'h106, 32'h0, rd);
    tests++;
    if (rd !== 32'hFFFF_DEAD) begin fails++; $display("FAIL lh got=%h exp=ffffdead", rd); end
  endtask

  task automatic test_eviction();
    logic [31:0] rd;
    do_reset();
    do_access(1'b1, 1'b0, 3'b010, 32'h1004, 32'hCAFE_F00D, rd);
    do_access(1'b0, 1'b1, 3'b010, 32'h2000, 32'h0, rd);
    do_access(1'b0, 1'b1, 3'b010, 32'h3000, 32'h0, rd);
    tests++;
    if (last_nph != 2) begin fails++; $display("FAIL dirty_evict_requests got=%0d exp=2", last_nph); end
    do_access(1'b0, 1'b1, 3'b010, 32'h2000, 32'h0, rd);
    tests++;
    if (last_stall != 0) begin fails++; $display("FAIL other_way_kept stall=%0d exp=0", last_stall); end
    do_access(1'b0, 1'b1, 3'b010, 32'h1004, 32'h0, rd);
    tests++;
    if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL written_back_data got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd;
    do_reset();
    do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, rd);
    address        = 32'h400;
    DATAMEMControl = 3'b010;
    read_enable    = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL miss_stall got=%b exp=1", stall); end
    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL refill_req mem_req=%b mem_we=%b exp=1/0", mem_req, mem_we);
    end
    mem_rdata = line_words(int'(mem_address), 1'b0);
    mem_ready = 1'b1;
    rst       = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0 || read_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_gates_outputs stall=%b read_data=%h exp=0/0", stall, read_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      fails++;
      $display("FAIL after_mid_reset mem_req=%b stall=%b exp=0/1", mem_req, stall);
    end
    read_enable = 1'b0;
    model_reset();
    @(negedge clk);
    do_access(1'b0, 1'b1, 3'b010, 32'h400, 32'h0, rd);
    tests++;
    if (last_nph != 1) begin fails++; $display("FAIL not_installed requests=%0d exp=1", last_nph); end
    do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, rd);
    tests++;
    if (last_nph != 1) begin fails++; $display("FAIL invalidated requests=%0d exp=1", last_nph); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd;
    logic [2:0]  f;
    bit          we, re;
    int          op, b;
    logic [2:0]  loads  [5];
    logic [2:0]  stores [3];
    loads  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    stores = '{3'b000, 3'b001, 3'b010};
    do_reset();
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      we = (op >= 4);
      re = (op < 4) || (op == 9);
      f  = we ? stores[$urandom_range(0, 2)] : loads[$urandom_range(0, 4)];
      b  = $urandom_range(0, 3);
      if (f[1:0] == 2'b01) b = b & 2;
      if (f == 3'b010)     b = 0;
      addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2) | 32'(b);
      wd = $urandom;
      do_access(we, re, f, addr, wd, rd);
    end
`ifdef MEMUNIT_STATS_EN
    tests++;
    if (hit_count !== 32'(model_hits) || miss_count !== 32'(model_misses)) begin
      fails++;
      $display("FAIL random_stats hits=%0d misses=%0d exp=%0d/%0d", hit_count, miss_count, model_hits, model_misses);
    end
`endif
  endtask

`ifdef MEMUNIT_STATS_EN
  task automatic test_stats();
    logic [31:0] rd;
    do_reset();
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, rd);
    do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, rd);
    do_access(1'b0, 1'b1, 3'b010, 32'h108, 32'h0, rd);
    do_access(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, rd);
    do_access(1'b0, 1'b1, 3'b010, 32'h10C, 32'h0, rd);
    tests++;
    if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
      fails++;
      $display("FAIL stats hits=%0d misses=%0d exp=3/2", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lanes();
    test_eviction();
    test_reset_mid_refill();
`ifdef MEMUNIT_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
